// File: rtl/sdram_arbiter.sv
// SDRAM command-bus arbiter: periodic auto-refresh scheduling with a postponed-refresh
// counter, exclusive non-preemptive grants to the refresh sequencer or the access engine.
`timescale 1ns/1ps
module sdram_arbiter #(
    parameter int REF_PERIOD  = 1560,
    parameter int URGENT      = 4,
    parameter int MAX_PENDING = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        init_done,
    input  logic        acc_req,
    output logic        acc_grant,
    input  logic        acc_end,
    input  logic [3:0]  acc_cmd,
    input  logic [12:0] acc_addr,
    input  logic [1:0]  acc_ba,
    output logic        ref_enable,
    input  logic        ref_end,
    input  logic [3:0]  ref_cmd,
    input  logic [12:0] ref_addr,
    input  logic [1:0]  ref_ba,
    output logic [12:0] dram_addr,
    output logic [1:0]  dram_ba,
    output logic        dram_cs_n,
    output logic        dram_ras_n,
    output logic        dram_cas_n,
    output logic        dram_we_n,
    output logic [3:0]  ref_pending,
    output logic        ref_overflow
);

    localparam int TW = $clog2(REF_PERIOD);
    localparam logic [TW-1:0] TIMER_LAST  = TW'(REF_PERIOD - 1);
    localparam logic [3:0]    PEND_MAX    = 4'(MAX_PENDING);
    localparam logic [3:0]    PEND_URGENT = 4'(URGENT);
    localparam logic [3:0]    CMD_NOP     = 4'b0111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REF  = 2'd1,
        ACC  = 2'd2
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [TW-1:0] timer;
    logic          tick;
    logic          ref_done;
    logic          ref_first;
    logic [3:0]    bus_cmd;

    assign tick     = init_done && (timer == TIMER_LAST);
    assign ref_done = ref_end && (state == REF);

    always_ff @(posedge clock) begin
        if (reset || !init_done) begin
            timer <= '0;
        end else if (tick) begin
            timer <= '0;
        end else begin
            timer <= timer + 1'b1;
        end
    end

    // A tick and a completed refresh in the same cycle cancel out.
    always_ff @(posedge clock) begin
        if (reset) begin
            ref_pending  <= '0;
            ref_overflow <= 1'b0;
        end else if (tick && !ref_done) begin
            if (ref_pending == PEND_MAX) begin
                ref_overflow <= 1'b1;
            end else begin
                ref_pending <= ref_pending + 1'b1;
            end
        end else if (ref_done && !tick && (ref_pending != 4'd0)) begin
            ref_pending <= ref_pending - 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            ref_first <= 1'b0;
        end else begin
            state     <= state_next;
            ref_first <= (state != REF) && (state_next == REF);
        end
    end

    // Urgent refresh outranks access; otherwise access wins over a postponable refresh.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (init_done) begin
                    if (ref_pending >= PEND_URGENT) begin
                        state_next = REF;
                    end else if (acc_req) begin
                        state_next = ACC;
                    end else if (ref_pending != 4'd0) begin
                        state_next = REF;
                    end
                end
            end
            REF: begin
                if (ref_end) begin
                    state_next = IDLE;
                end
            end
            ACC: begin
                if (acc_end) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign acc_grant  = (state == ACC);
    assign ref_enable = ref_first;

    always_comb begin
        bus_cmd   = CMD_NOP;
        dram_addr = '0;
        dram_ba   = '0;
        if (init_done && (state == REF)) begin
            bus_cmd   = ref_cmd;
            dram_addr = ref_addr;
            dram_ba   = ref_ba;
        end else if (init_done && (state == ACC)) begin
            bus_cmd   = acc_cmd;
            dram_addr = acc_addr;
            dram_ba   = acc_ba;
        end
    end

    assign {dram_cs_n, dram_ras_n, dram_cas_n, dram_we_n} = bus_cmd;

endmodule
